// File: rtl/seq_stage_controller.sv
// seq_stage_controller: Y86 multi-cycle stage sequencer; define INSTR_COUNT_EN to enable the retired-instruction counter
module seq_stage_controller #(
  parameter int MEM_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [3:0]  icode,
  input  logic        imem_error,
  input  logic        mem_ack,
  input  logic        dmem_error,
  output logic        fetch_en,
  output logic        decode_en,
  output logic        exec_en,
  output logic        wb_en,
  output logic        pc_en,
  output logic        mem_req,
  output logic        mem_write,
  output logic [2:0]  stat,
  output logic        busy,
  output logic [31:0] instr_count
);
  localparam logic [2:0] IDLE = 3'd0, FETCH = 3'd1, DECODE = 3'd2, EXECUTE = 3'd3,
                         MEMORY = 3'd4, WRITEBACK = 3'd5, PCUPD = 3'd6, HALTED = 3'd7;
  localparam logic [2:0] AOK = 3'd1, HLT = 3'd2, ADR = 3'd3, INS = 3'd4;
  logic [2:0] state, nxt, nstat;
  logic [3:0] latched_icode, wcnt;
  logic       is_mem, timed_out;
  assign is_mem    = latched_icode inside {4'h4, 4'h5, 4'h8, 4'h9, 4'hA, 4'hB};
  assign timed_out = wcnt == 4'(MEM_TIMEOUT - 1);
  assign fetch_en  = state == FETCH;
  assign decode_en = state == DECODE;
  assign exec_en   = state == EXECUTE;
  assign wb_en     = state == WRITEBACK;
  assign pc_en     = state == PCUPD;
  assign mem_req   = state == MEMORY;
  assign mem_write = mem_req && latched_icode inside {4'h4, 4'h8, 4'hA};
  assign busy      = state != IDLE && state != HALTED;
  // next state and next status from current state and inputs
  always_comb begin
    nxt = state;
    nstat = stat;
    case (state)
      IDLE: nxt = start ? FETCH : IDLE;
      FETCH: begin
        nxt = (imem_error || icode > 4'hB || icode == 4'h0) ? HALTED : DECODE;
        nstat = imem_error ? ADR : icode > 4'hB ? INS : icode == 4'h0 ? HLT : stat;
      end
      DECODE: nxt = EXECUTE;
      EXECUTE: nxt = is_mem ? MEMORY : (latched_icode == 4'h1 || latched_icode == 4'h7) ? PCUPD : WRITEBACK;
      MEMORY: begin
        nxt = mem_ack ? (dmem_error ? HALTED : latched_icode == 4'h4 ? PCUPD : WRITEBACK)
                      : (timed_out ? HALTED : MEMORY);
        nstat = (mem_ack ? dmem_error : timed_out) ? ADR : stat;
      end
      WRITEBACK: nxt = PCUPD;
      PCUPD: nxt = stop ? IDLE : FETCH;
      default: nxt = state;
    endcase
  end
  // state, status, latched icode and memory wait counter; wait counter is held at zero outside MEMORY so it is clear on entry
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      stat <= AOK;
      latched_icode <= 4'h0;
      wcnt <= 4'h0;
    end else begin
      state <= nxt;
      stat <= nstat;
      if (state == FETCH) latched_icode <= icode;
      wcnt <= (state != MEMORY) ? 4'h0 : mem_ack ? wcnt : wcnt + 4'h1;
    end
  end
`ifdef INSTR_COUNT_EN
  // count one retired instruction per PCUPD cycle, wrapping naturally
  always_ff @(posedge clk) begin
    if (reset) instr_count <= 32'h0;
    else if (state == PCUPD) instr_count <= instr_count + 32'h1;
  end
`else
  assign instr_count = 32'h0;
`endif
endmodule

// File: tb/tb_seq_stage_controller.sv
// tb_seq_stage_controller: directed scoreboard bench for seq_stage_controller
module tb_seq_stage_controller;
  localparam int S_IDLE = 0, S_F = 1, S_D = 2, S_E = 3, S_M = 4, S_W = 5, S_P = 6, S_H = 7;
  logic clk = 0, reset = 0, start = 0, stop = 0, imem_error = 0, mem_ack = 0, dmem_error = 0;
  logic [3:0] icode = 4'h0;
  logic fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, mem_write, busy;
  logic [2:0] stat;
  logic [31:0] instr_count, exp_cnt = 0;
  logic [10:0] q[$];
  int tests = 0, fails = 0;
  seq_stage_controller dut (
    .clk(clk), .reset(reset), .start(start), .stop(stop), .icode(icode),
    .imem_error(imem_error), .mem_ack(mem_ack), .dmem_error(dmem_error),
    .fetch_en(fetch_en), .decode_en(decode_en), .exec_en(exec_en), .wb_en(wb_en),
    .pc_en(pc_en), .mem_req(mem_req), .mem_write(mem_write), .stat(stat),
    .busy(busy), .instr_count(instr_count)
  );
  always #5 clk = ~clk;
  function automatic logic [10:0] ex(int s, logic mw, logic [2:0] st);
    return {s == S_F, s == S_D, s == S_E, s == S_W, s == S_P, s == S_M, mw, s != S_IDLE && s != S_H, st};
  endfunction
  task automatic chk(string tag, logic [10:0] e);
    logic [10:0] obs, want;
    logic [31:0] want_cnt;
    q.push_back(e);
    @(posedge clk);
    #1;
    want = q.pop_front();
    obs = {fetch_en, decode_en, exec_en, wb_en, pc_en, mem_req, mem_write, busy, stat};
    tests++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s outputs got %b exp %b", tag, obs, want);
    end
    if (reset) exp_cnt = 0;
`ifdef INSTR_COUNT_EN
    want_cnt = exp_cnt;
`else
    want_cnt = 0;
`endif
    tests++;
    assert (instr_count === want_cnt) else begin
      fails++;
      $error("FAIL %s instr_count got %0d exp %0d", tag, instr_count, want_cnt);
    end
    if (want[6]) exp_cnt++;
  endtask
  task automatic rst;
    reset = 1; start = 0; stop = 0; mem_ack = 0; dmem_error = 0; imem_error = 0;
    chk("reset", ex(S_IDLE, 0, 1));
    reset = 0;
  endtask
  initial begin
    #2;
    rst();
    start = 1; icode = 4'h6; chk("opq_f", ex(S_F, 0, 1));
    start = 0; chk("opq_d", ex(S_D, 0, 1));
    chk("opq_e", ex(S_E, 0, 1));
    chk("opq_w", ex(S_W, 0, 1));
    stop = 1; chk("opq_p", ex(S_P, 0, 1));
    chk("opq_idle", ex(S_IDLE, 0, 1));
    stop = 0; icode = 4'h5; start = 1; chk("mr_f", ex(S_F, 0, 1));
    start = 0; mem_ack = 1; chk("mr_d", ex(S_D, 0, 1));
    mem_ack = 0; chk("mr_e", ex(S_E, 0, 1));
    chk("mr_m0", ex(S_M, 0, 1));
    for (int i = 0; i < 3; i++) chk("mr_wait", ex(S_M, 0, 1));
    mem_ack = 1; chk("mr_w", ex(S_W, 0, 1));
    mem_ack = 0; stop = 1; chk("mr_p", ex(S_P, 0, 1));
    chk("mr_idle", ex(S_IDLE, 0, 1));
    stop = 0; icode = 4'h4; start = 1; chk("rm_f", ex(S_F, 0, 1));
    start = 0; chk("rm_d", ex(S_D, 0, 1));
    chk("rm_e", ex(S_E, 0, 1));
    chk("rm_m", ex(S_M, 1, 1));
    mem_ack = 1; dmem_error = 1; chk("dmem_halt", ex(S_H, 0, 3));
    mem_ack = 0; dmem_error = 0; start = 1; chk("halt_hold", ex(S_H, 0, 3));
    chk("halt_hold2", ex(S_H, 0, 3));
    rst();
    icode = 4'hC; start = 1; chk("ins_f", ex(S_F, 0, 1));
    start = 0; chk("ins_halt", ex(S_H, 0, 4));
    rst();
    icode = 4'h0; start = 1; chk("hlt_f", ex(S_F, 0, 1));
    start = 0; chk("hlt_halt", ex(S_H, 0, 2));
    rst();
    imem_error = 1; start = 1; chk("imem_f", ex(S_F, 0, 1));
    start = 0; chk("imem_halt", ex(S_H, 0, 3));
    rst();
    icode = 4'h4; start = 1; chk("rm2_f", ex(S_F, 0, 1));
    start = 0; chk("rm2_d", ex(S_D, 0, 1));
    chk("rm2_e", ex(S_E, 0, 1));
    mem_ack = 1; chk("rm2_m", ex(S_M, 1, 1));
    chk("rm2_p", ex(S_P, 0, 1));
    mem_ack = 0; icode = 4'h7; chk("jxx_f", ex(S_F, 0, 1));
    chk("jxx_d", ex(S_D, 0, 1));
    chk("jxx_e", ex(S_E, 0, 1));
    stop = 1; chk("jxx_p", ex(S_P, 0, 1));
    chk("jxx_idle", ex(S_IDLE, 0, 1));
    stop = 0; icode = 4'h8; start = 1; chk("to_f", ex(S_F, 0, 1));
    start = 0; chk("to_d", ex(S_D, 0, 1));
    chk("to_e", ex(S_E, 0, 1));
    chk("to_m1", ex(S_M, 1, 1));
    for (int i = 0; i < 14; i++) chk("to_wait", ex(S_M, 1, 1));
    chk("to_halt", ex(S_H, 0, 3));
    rst();
    icode = 4'h5; start = 1; chk("mr3_f", ex(S_F, 0, 1));
    start = 0; chk("mr3_d", ex(S_D, 0, 1));
    chk("mr3_e", ex(S_E, 0, 1));
    chk("mr3_m1", ex(S_M, 0, 1));
    chk("mr3_m2", ex(S_M, 0, 1));
    reset = 1; start = 1; mem_ack = 1; chk("mid_mem_reset", ex(S_IDLE, 0, 1));
    reset = 0; mem_ack = 0; icode = 4'h1; chk("restart_f", ex(S_F, 0, 1));
    start = 0; chk("nop_d", ex(S_D, 0, 1));
    chk("nop_e", ex(S_E, 0, 1));
    stop = 1; chk("nop_p", ex(S_P, 0, 1));
    chk("nop_idle", ex(S_IDLE, 0, 1));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
